audio_rx_decoder: RTL and testbench

AUDIO_RX_DECODER -- requirements
Module: audio_rx_decoder

---
 rtl/audio_rx_decoder.sv | 152 +++++++++++++++
 tb/tb_audio_rx_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_rx_decoder.sv
// I2S ADC receiver: derives mclk/sck/lrck from a 10-bit counter and captures left/right sample pairs.
// Optional peak level meter is built only when macro AUDIO_RX_LEVEL_METER_EN is defined.
module audio_rx_decoder #(
  parameter int         DATA_W       = 16,
  parameter logic [3:0] SAMPLE_PHASE = 4'd11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              audio_sdout,
  output logic              audio_mclk,
  output logic              audio_lrck,
  output logic              audio_sck,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              sample_valid,
  input  logic              sample_ack,
  output logic              overrun,
  input  logic              clr_ovr,
  output logic [3:0]        level
);
  localparam logic [4:0] LAST_SLOT = 5'(DATA_W);
  localparam logic [9:0] DONE_CNT  = {1'b1, LAST_SLOT, SAMPLE_PHASE};

  logic [9:0]        cnt;
  logic [1:0]        sync_q;
  logic              sdout_s;
  logic [4:0]        slot;
  logic              half;
  logic              bit_tick;
  logic              frame_done;
  logic              ack_take;
  logic [DATA_W-1:0] shift_left;
  logic [DATA_W-1:0] shift_right;
  logic [DATA_W-1:0] left_word;
  logic [DATA_W-1:0] right_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (!en) cnt <= '0;
    else          cnt <= cnt + 10'd1;
  end

  // Gate with en so the ADC sees quiet clocks as soon as capture is disabled.
  assign audio_mclk = en & cnt[1];
  assign audio_sck  = en & cnt[3];
  assign audio_lrck = en & cnt[9];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], audio_sdout};
  end

  assign sdout_s    = sync_q[1];
  assign slot       = cnt[8:4];
  assign half       = cnt[9];
  assign bit_tick   = en && (cnt[3:0] == SAMPLE_PHASE) && (slot != 5'd0) && (slot <= LAST_SLOT);
  assign frame_done = en && (cnt == DONE_CNT);
  assign ack_take   = sample_ack && sample_valid;

  // The final right bit arrives in the completion cycle, so the output uses the shifted word.
  assign left_word  = (DATA_W)'({shift_left, sdout_s});
  assign right_word = (DATA_W)'({shift_right, sdout_s});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_left  <= '0;
      shift_right <= '0;
    end else if (!en || frame_done) begin
      shift_left  <= '0;
      shift_right <= '0;
    end else if (bit_tick) begin
      if (half) shift_right <= right_word;
      else      shift_left  <= left_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
    end else if (frame_done) begin
      sample_left  <= shift_left;
      sample_right <= right_word;
      sample_valid <= 1'b1;
    end else if (ack_take) begin
      sample_valid <= 1'b0;
    end
  end

  // An unconsumed pair being overwritten beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          overrun <= 1'b0;
    else if (frame_done && sample_valid && !sample_ack) overrun <= 1'b1;
    else if (clr_ovr)                                 overrun <= 1'b0;
  end

`ifdef AUDIO_RX_LEVEL_METER_EN
  localparam logic [DATA_W-1:0] MIN_NEG = (DATA_W)'(1) << (DATA_W - 1);

  logic [DATA_W-1:0] mag_l;
  logic [DATA_W-1:0] mag_r;
  logic [DATA_W-1:0] peak_m;
  logic [3:0]        frame_b;
  logic [3:0]        cand;
  logic [3:0]        peak;
  logic [7:0]        win_cnt;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    if (!x[DATA_W-1]) return x;
    if (x == MIN_NEG) return ~MIN_NEG;
    return ~x + (DATA_W)'(1);
  endfunction

  function automatic logic [3:0] bucket(input logic [DATA_W-1:0] m);
    logic [4:0] b;
    b = 5'd0;
    for (int i = 0; i < DATA_W; i++)
      if (m[i]) b = 5'(i + 1);
    return (b > 5'd15) ? 4'd15 : b[3:0];
  endfunction

  always_comb begin
    mag_l   = mag(shift_left);
    mag_r   = mag(right_word);
    peak_m  = (mag_l > mag_r) ? mag_l : mag_r;
    frame_b = bucket(peak_m);
    cand    = (frame_b > peak) ? frame_b : peak;
  end

  // 256-frame window: publish the running max on the last frame and restart from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      peak    <= '0;
      level   <= '0;
    end else if (frame_done) begin
      win_cnt <= win_cnt + 8'd1;
      if (win_cnt == 8'hFF) begin
        level <= cand;
        peak  <= '0;
      end else begin
        peak <= cand;
      end
    end
  end
`else
  assign level = 4'd0;
`endif

endmodule

// File: tb/tb_audio_rx_decoder.sv
// Self-checking bench for audio_rx_decoder: an I2S ADC model clocked by the DUT's sck/lrck
// feeds frames, and a scoreboard queue holds the pairs expected at each frame completion.
module tb_audio_rx_decoder;
  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        audio_sdout = 1'b0;
  logic        sample_ack = 1'b0;
  logic        clr_ovr = 1'b0;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        overrun;
  logic [3:0]  level;

  int checks = 0;
  int errors = 0;

  frame_t     tx_q[$];
  frame_t     exp_q[$];
  frame_t     cur = '0;
  logic [9:0] pos;
  int         bitpos = 0;
  logic       last_lrck = 1'b0;
  logic       last_sck = 1'b0;

  audio_rx_decoder #(.DATA_W(16), .SAMPLE_PHASE(4'd11)) dut (
    .clk(clk), .rst(rst), .en(en), .audio_sdout(audio_sdout),
    .audio_mclk(audio_mclk), .audio_lrck(audio_lrck), .audio_sck(audio_sck),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ack(sample_ack),
    .overrun(overrun), .clr_ovr(clr_ovr), .level(level)
  );

  always #5 clk = ~clk;

  // Frame position reference: 0 at enable, one step per clock while enabled.
  always @(posedge clk or posedge rst) begin
    if (rst)      pos <= '0;
    else if (!en) pos <= '0;
    else          pos <= pos + 10'd1;
  end

  // ADC model: shifts a new bit after each sck falling edge, MSB one slot after the lrck change.
  always @(posedge clk) begin
    #2;
    if (rst || !en) begin
      bitpos      = 0;
      last_lrck   = 1'b0;
      last_sck    = 1'b0;
      audio_sdout = 1'b0;
    end else begin
      if (last_sck && !audio_sck) begin
        if (audio_lrck != last_lrck) bitpos = 0;
        else                         bitpos++;
        last_lrck = audio_lrck;
        if (!audio_lrck && bitpos == 1) cur = (tx_q.size() > 0) ? tx_q.pop_front() : '0;
        if (audio_lrck && bitpos == 16) exp_q.push_back(cur);
        if (bitpos >= 1 && bitpos <= 16)
          audio_sdout = audio_lrck ? cur.r[16 - bitpos] : cur.l[16 - bitpos];
        else
          audio_sdout = 1'b0;
      end
      last_sck = audio_sck;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
    frame_t f;
    f.l = l;
    f.r = r;
    tx_q.push_back(f);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_pos(input logic [9:0] p, input string tag);
    int n;
    n = 0;
    while (pos !== p && n < 1100) begin
      step();
      n++;
    end
    checks++;
    assert (pos === p) else begin
      errors++;
      $error("[TB] FAIL %s timeout pos=%0d expected=%0d", tag, pos, p);
    end
  endtask

  task automatic check_frame(input string tag);
    frame_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("[TB] FAIL %s_queue observed=empty expected=frame", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({tag, "_left"}, 32'(sample_left), 32'(e.l));
      checkOutput({tag, "_right"}, 32'(sample_right), 32'(e.r));
    end
  endtask

  initial begin
    #60_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    applyStimulus(16'h1234, 16'hF00D);
    step();
    step();
    checkOutput("rst_left", 32'(sample_left), 0);
    checkOutput("rst_right", 32'(sample_right), 0);
    checkOutput("rst_valid", 32'(sample_valid), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_mclk", 32'(audio_mclk), 0);
    checkOutput("rst_lrck", 32'(audio_lrck), 0);
    checkOutput("rst_sck", 32'(audio_sck), 0);

    // First frame: valid must appear exactly when the counter reaches 780.
    rst = 1'b0;
    en  = 1'b1;
    wait_pos(10'd779, "f1_wait");
    checkOutput("f1_valid_early", 32'(sample_valid), 0);
    step();
    checkOutput("f1_valid", 32'(sample_valid), 1);
    checkOutput("f1_lrck", 32'(audio_lrck), 1);
    checkOutput("f1_sck", 32'(audio_sck), 1);
    checkOutput("f1_mclk", 32'(audio_mclk), 0);
    check_frame("f1");

    // Second frame without ack overwrites and flags overrun.
    applyStimulus(16'h0001, 16'h5555);
    step();
    wait_pos(10'd780, "f2_wait");
    checkOutput("f2_overrun", 32'(overrun), 1);
    checkOutput("f2_valid", 32'(sample_valid), 1);
    check_frame("f2");
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    checkOutput("clr_ovr", 32'(overrun), 0);
    checkOutput("clr_valid", 32'(sample_valid), 1);

    // Ack landing in the completion cycle: new data, valid held, no overrun.
    applyStimulus(16'h7FFF, 16'h8000);
    step();
    wait_pos(10'd779, "f3_wait");
    sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;
    checkOutput("f3_valid", 32'(sample_valid), 1);
    checkOutput("f3_overrun", 32'(overrun), 0);
    check_frame("f3");
    sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;
    checkOutput("ack_clear", 32'(sample_valid), 0);
    sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;
    checkOutput("ack_idle_valid", 32'(sample_valid), 0);
    checkOutput("ack_idle_overrun", 32'(overrun), 0);

    // Drop enable mid left half; the broken frame must never complete.
    applyStimulus(16'hAAAA, 16'hBBBB);
    wait_pos(10'd300, "drop_wait");
    checkOutput("hold_left", 32'(sample_left), 32'h7FFF);
    checkOutput("hold_right", 32'(sample_right), 32'h8000);
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (audio_sck !== 1'b0 || audio_lrck !== 1'b0 || audio_mclk !== 1'b0 || sample_valid !== 1'b0)
        bad++;
    end
    checkOutput("en_off_quiet", 32'(bad), 0);
    checkOutput("en_off_left", 32'(sample_left), 32'h7FFF);
    applyStimulus(16'h1357, 16'h2468);
    en = 1'b1;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (audio_sck !== pos[3] || audio_lrck !== pos[9] || audio_mclk !== pos[1]) bad++;
    end
    checkOutput("clock_gen", 32'(bad), 0);
    wait_pos(10'd779, "f5_wait");
    checkOutput("f5_valid_early", 32'(sample_valid), 0);
    step();
    checkOutput("f5_valid", 32'(sample_valid), 1);
    checkOutput("f5_overrun", 32'(overrun), 0);
    check_frame("f5");
    sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;

    // Reset in the middle of the right half, then a clean restart.
    applyStimulus(16'hCCCC, 16'hDDDD);
    wait_pos(10'd600, "rst_wait");
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_left", 32'(sample_left), 0);
    checkOutput("mid_rst_right", 32'(sample_right), 0);
    checkOutput("mid_rst_valid", 32'(sample_valid), 0);
    checkOutput("mid_rst_lrck", 32'(audio_lrck), 0);
    checkOutput("mid_rst_sck", 32'(audio_sck), 0);
    applyStimulus(16'h0F0F, 16'hF0F0);
    step();
    step();
    step();
    rst = 1'b0;
    wait_pos(10'd779, "f7_wait");
    checkOutput("f7_valid_early", 32'(sample_valid), 0);
    step();
    checkOutput("f7_valid", 32'(sample_valid), 1);
    check_frame("f7");

`ifdef AUDIO_RX_LEVEL_METER_EN
    for (int i = 0; i < 512; i++) applyStimulus(16'h0400, 16'hFE00);
    for (int i = 0; i < 512; i++) begin
      step();
      wait_pos(10'd780, "meter_hi_wait");
    end
    checkOutput("level_hi", 32'(level), 11);
    for (int i = 0; i < 512; i++) applyStimulus(16'h0000, 16'h0000);
    for (int i = 0; i < 512; i++) begin
      step();
      wait_pos(10'd780, "meter_lo_wait");
    end
    checkOutput("level_lo", 32'(level), 0);
    exp_q.delete();
`else
    checkOutput("level_off", 32'(level), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
